// File: rtl/baseball_scoreboard_pkg.sv
// Shared action codes, result codes and FSM states for the baseball scoreboard.
package baseball_pkg;

    localparam logic [2:0] ACT_WALK   = 3'd0;
    localparam logic [2:0] ACT_SINGLE = 3'd1;
    localparam logic [2:0] ACT_DOUBLE = 3'd2;
    localparam logic [2:0] ACT_TRIPLE = 3'd3;
    localparam logic [2:0] ACT_HR     = 3'd4;
    localparam logic [2:0] ACT_BUNT   = 3'd5;
    localparam logic [2:0] ACT_GROUND = 3'd6;
    localparam logic [2:0] ACT_FLY    = 3'd7;

    localparam logic [1:0] RES_A_WIN = 2'd0;
    localparam logic [1:0] RES_B_WIN = 2'd1;
    localparam logic [1:0] RES_DRAW  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/baseball_scoreboard_base_advance.sv
// Combinational base-running rules: given the diamond before a batter's action,
// produce the diamond after it, the runs that crossed the plate and the outs recorded.
module base_advance
    import baseball_pkg::*;
#(
    parameter int OUTS_LIMIT = 3
) (
    input  logic [2:0] bases,
    input  logic [1:0] outs,
    input  logic [2:0] action,
    output logic [2:0] next_bases,
    output logic [2:0] runs,
    output logic [1:0] outs_added
);

    logic [2:0] w_occupied;
    logic       w_buntEndsHalf;

    assign w_occupied     = {2'b00, bases[0]} + {2'b00, bases[1]} + {2'b00, bases[2]};
    assign w_buntEndsHalf = ({1'b0, outs} + 3'd1) >= 3'(OUTS_LIMIT);

    // bases are {3rd, 2nd, 1st}; a runner pushed past 3rd becomes a run
    always_comb begin
        next_bases = bases;
        runs       = 3'd0;
        outs_added = 2'd0;
        case (action)
            ACT_WALK: begin
                next_bases = bases[0] ? (bases[1] ? 3'b111 : {bases[2], 2'b11})
                                      : {bases[2], bases[1], 1'b1};
                runs       = {2'b00, &bases};
            end
            ACT_SINGLE: begin
                if (outs == 2'd2) begin
                    next_bases = {bases[0], 2'b01};
                    runs       = {2'b00, bases[2]} + {2'b00, bases[1]};
                end else begin
                    next_bases = {bases[1], bases[0], 1'b1};
                    runs       = {2'b00, bases[2]};
                end
            end
            ACT_DOUBLE: begin
                next_bases = {bases[0], 2'b10};
                runs       = {2'b00, bases[2]} + {2'b00, bases[1]};
            end
            ACT_TRIPLE: begin
                next_bases = 3'b100;
                runs       = w_occupied;
            end
            ACT_HR: begin
                next_bases = 3'b000;
                runs       = w_occupied + 3'd1;
            end
            ACT_BUNT: begin
                outs_added = 2'd1;
                if (!w_buntEndsHalf) begin
                    next_bases = {bases[1], bases[0], 1'b0};
                    runs       = {2'b00, bases[2]};
                end
            end
            ACT_GROUND: begin
                // runner forced from 1st is doubled up along with the batter
                outs_added = 2'd1 + {1'b0, bases[0]};
                next_bases = {bases[1], 2'b00};
                runs       = {2'b00, bases[2]};
            end
            ACT_FLY: begin
                outs_added = 2'd1;
                if (outs < 2'd2) begin
                    next_bases = {1'b0, bases[1:0]};
                    runs       = {2'b00, bases[2]};
                end
            end
            default: begin
                next_bases = bases;
            end
        endcase
    end

endmodule

// File: rtl/baseball_scoreboard.sv
// Scores a three-inning game from a burst of per-batter actions and pulses the
// final score and winner once, two cycles after the burst ends.
module baseball_scoreboard
    import baseball_pkg::*;
#(
    parameter int SCORE_W    = 8,
    parameter int OUTS_LIMIT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [1:0]         inning,
    input  logic               half,
    input  logic [2:0]         action,
    output logic               out_valid,
    output logic [SCORE_W-1:0] score_A,
    output logic [SCORE_W-1:0] score_B,
    output logic [1:0]         result
);

    localparam logic [2:0] LIMIT = 3'(OUTS_LIMIT);

    state_t             r_state;
    state_t             w_nextState;
    logic [2:0]         r_bases;
    logic [1:0]         r_outs;
    logic               r_half;
    logic [SCORE_W-1:0] r_scoreA;
    logic [SCORE_W-1:0] r_scoreB;
    logic [1:0]         r_lastInning;
    logic [7:0]         r_unusedInningChanges;

    logic               w_accept;
    logic               w_freshHalf;
    logic [2:0]         w_curBases;
    logic [1:0]         w_curOuts;
    logic               w_halfOver;
    logic [2:0]         w_nextBases;
    logic [2:0]         w_runs;
    logic [1:0]         w_outsAdded;
    logic [2:0]         w_outSum;
    logic               w_endsHalf;
    logic [SCORE_W-1:0] w_credit;
    logic [SCORE_W-1:0] w_baseA;
    logic [SCORE_W-1:0] w_baseB;
    logic [1:0]         w_result;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_nextState = PLAY;
            PLAY:    if (!in_valid) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // A new game or a change of half starts from an empty diamond with no outs
    assign w_accept    = in_valid && (r_state != DONE);
    assign w_freshHalf = (r_state != PLAY) || (half != r_half);
    assign w_curBases  = w_freshHalf ? 3'b000 : r_bases;
    assign w_curOuts   = w_freshHalf ? 2'd0 : r_outs;
    assign w_halfOver  = {1'b0, w_curOuts} >= LIMIT;

    base_advance #(.OUTS_LIMIT(OUTS_LIMIT)) u_advance (
        .bases      (w_curBases),
        .outs       (w_curOuts),
        .action     (action),
        .next_bases (w_nextBases),
        .runs       (w_runs),
        .outs_added (w_outsAdded)
    );

    assign w_outSum   = {1'b0, w_curOuts} + {1'b0, w_outsAdded};
    assign w_endsHalf = w_outSum >= LIMIT;
    assign w_credit   = w_endsHalf ? '0 : SCORE_W'(w_runs);
    assign w_baseA    = (r_state == PLAY) ? r_scoreA : '0;
    assign w_baseB    = (r_state == PLAY) ? r_scoreB : '0;
    assign w_result   = (r_scoreA > r_scoreB) ? RES_A_WIN :
                        (r_scoreB > r_scoreA) ? RES_B_WIN : RES_DRAW;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state               <= IDLE;
            r_bases               <= 3'b000;
            r_outs                <= 2'd0;
            r_half                <= 1'b0;
            r_scoreA              <= '0;
            r_scoreB              <= '0;
            r_lastInning          <= 2'd0;
            r_unusedInningChanges <= 8'd0;
            out_valid             <= 1'b0;
            score_A               <= '0;
            score_B               <= '0;
            result                <= RES_A_WIN;
        end else begin
            r_state   <= w_nextState;
            out_valid <= (r_state == DONE);
            score_A   <= (r_state == DONE) ? r_scoreA : '0;
            score_B   <= (r_state == DONE) ? r_scoreB : '0;
            result    <= (r_state == DONE) ? w_result : RES_A_WIN;
            if (w_accept) begin
                r_half       <= half;
                r_lastInning <= inning;
                if (inning != r_lastInning) begin
                    r_unusedInningChanges <= r_unusedInningChanges + 8'd1;
                end
                // actions after the half's last out are dropped until half flips
                if (!w_halfOver) begin
                    r_bases  <= w_endsHalf ? 3'b000 : w_nextBases;
                    r_outs   <= w_endsHalf ? LIMIT[1:0] : w_outSum[1:0];
                    r_scoreA <= w_baseA + (half ? '0 : w_credit);
                    r_scoreB <= w_baseB + (half ? w_credit : '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_baseball_scoreboard.sv
// Drives whole games, predicts each final score with an independent runner-by-runner
// model and compares every strobed result against a queue of expectations.
module tb_baseball_scoreboard;

    typedef struct {
        int a;
        int b;
        int r;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] inning;
    logic       half;
    logic [2:0] action;
    logic       out_valid;
    logic [7:0] score_A;
    logic [7:0] score_B;
    logic [1:0] result;

    int   totalChecks = 0;
    int   badChecks   = 0;
    exp_t expQ[$];
    int   plan[$];
    bit   monOn = 0;
    int   idleCount = 100;

    bit [2:0]   mBases;
    int         mOuts;
    int         mHalf;
    bit         mFresh;
    logic [7:0] mA;
    logic [7:0] mB;

    baseball_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .inning    (inning),
        .half      (half),
        .action    (action),
        .out_valid (out_valid),
        .score_A   (score_A),
        .score_B   (score_B),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        totalChecks++;
        if (got != exp) begin
            badChecks++;
            $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic moveRunners(input bit [2:0] b, input int adv, input int firstBase,
                               output bit [2:0] nb, inout int runs);
        nb = 3'b000;
        for (int r = firstBase; r <= 3; r++) begin
            if (b[r-1]) begin
                if (r + adv >= 4) runs++;
                else nb[r+adv-1] = 1'b1;
            end
        end
    endtask

    task automatic modelStep(input int hf, input int act);
        bit [2:0] nb;
        int runs;
        int added;
        if (mFresh || hf != mHalf) begin
            mBases = 3'b000;
            mOuts  = 0;
        end
        mFresh = 1'b0;
        mHalf  = hf;
        if (mOuts >= 3) return;
        runs  = 0;
        added = 0;
        nb    = mBases;
        case (act)
            0: begin
                if (mBases[0]) begin
                    if (mBases[1]) begin
                        if (mBases[2]) runs = 1;
                        nb[2] = 1'b1;
                    end
                    nb[1] = 1'b1;
                end
                nb[0] = 1'b1;
            end
            1: begin moveRunners(mBases, (mOuts == 2) ? 2 : 1, 1, nb, runs); nb[0] = 1'b1; end
            2: begin moveRunners(mBases, 2, 1, nb, runs); nb[1] = 1'b1; end
            3: begin moveRunners(mBases, 3, 1, nb, runs); nb[2] = 1'b1; end
            4: begin moveRunners(mBases, 4, 1, nb, runs); runs++; end
            5: begin
                added = 1;
                if (mOuts + 1 < 3) moveRunners(mBases, 1, 1, nb, runs);
            end
            6: begin
                added = 1 + int'(mBases[0]);
                moveRunners(mBases, 1, 2, nb, runs);
            end
            default: begin
                added = 1;
                if (mOuts < 2 && mBases[2]) begin
                    runs  = 1;
                    nb[2] = 1'b0;
                end
            end
        endcase
        if (mOuts + added >= 3) begin
            mOuts  = 3;
            mBases = 3'b000;
        end else begin
            mOuts  = mOuts + added;
            mBases = nb;
            if (hf == 0) mA = mA + 8'(runs);
            else mB = mB + 8'(runs);
        end
    endtask

    function automatic bit halfDone(input int hf);
        return !mFresh && mHalf == hf && mOuts >= 3;
    endfunction

    task automatic applyStimulus(input int inn, input int hf, input int act);
        @(negedge clk);
        in_valid = 1'b1;
        inning   = 2'(inn);
        half     = 1'(hf);
        action   = 3'(act);
        modelStep(hf, act);
    endtask

    task automatic startGame();
        mFresh = 1'b1;
        mA     = 8'd0;
        mB     = 8'd0;
    endtask

    task automatic endGame();
        exp_t e;
        @(negedge clk);
        in_valid = 1'b0;
        e.a = int'(mA);
        e.b = int'(mB);
        e.r = (mA > mB) ? 0 : (mB > mA) ? 1 : 2;
        expQ.push_back(e);
        repeat (6) @(negedge clk);
    endtask

    // plan holds actions per half, 8 closes a half; unplanned outs are fly balls
    task automatic runGame(input bit rnd);
        int a;
        startGame();
        for (int h = 0; h < 6; h++) begin
            if (rnd) begin
                for (int k = 0; k < 10; k++)
                    if (!halfDone(h % 2)) applyStimulus(h / 2 + 1, h % 2, int'($urandom_range(0, 7)));
            end else begin
                while (plan.size() > 0) begin
                    a = plan.pop_front();
                    if (a == 8) break;
                    applyStimulus(h / 2 + 1, h % 2, a);
                end
            end
            while (!halfDone(h % 2)) applyStimulus(h / 2 + 1, h % 2, 7);
        end
        endGame();
    endtask

    always @(negedge clk) begin
        #1;
        if (monOn) begin
            exp_t e;
            bit expOv;
            if (in_valid) idleCount = 0;
            else if (idleCount < 100) idleCount++;
            expOv = (idleCount == 3) && (expQ.size() > 0);
            checkOutput("out_valid", int'(out_valid), int'(expOv));
            if (out_valid && expOv) begin
                e = expQ.pop_front();
                checkOutput("score_A", int'(score_A), e.a);
                checkOutput("score_B", int'(score_B), e.b);
                checkOutput("result", int'(result), e.r);
            end else if (!out_valid) begin
                checkOutput("idle_score_A", int'(score_A), 0);
                checkOutput("idle_score_B", int'(score_B), 0);
                checkOutput("idle_result", int'(result), 0);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        inning   = 2'd1;
        half     = 1'b0;
        action   = 3'd0;
        mFresh   = 1'b1;
        mHalf    = 0;
        mOuts    = 0;
        mBases   = 3'b000;
        mA       = 8'd0;
        mB       = 8'd0;
        repeat (2) @(negedge clk);
        monOn = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        plan = '{0, 0, 0, 0, 6, 6, 6, 8};
        runGame(1'b0);

        plan = '{8, 8, 8, 0, 0, 0, 4, 8};
        runGame(1'b0);

        plan = '{7, 7, 3, 7, 8, 7, 3, 7, 7, 8, 7, 0, 6, 8, 4, 8};
        runGame(1'b0);

        plan = '{4, 4, 8, 0, 1, 2, 7, 7, 7, 4, 8, 5, 1, 8};
        runGame(1'b0);

        startGame();
        applyStimulus(1, 0, 4);
        applyStimulus(1, 0, 7);
        applyStimulus(1, 0, 7);
        applyStimulus(1, 0, 7);
        applyStimulus(1, 1, 4);
        applyStimulus(2, 0, 3);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        plan = '{8, 8, 8, 8, 4, 8};
        runGame(1'b0);

        for (int g = 0; g < 4; g++) runGame(1'b1);

        repeat (5) @(negedge clk);
        checkOutput("drain", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
